vram_line_arbiter: RTL and testbench

- Shares the single VRAM line port (one LINE_W-bit line per address) among several text-panel writers, e.g. register panel, memory panel and console.
- Each write_letter-style client gets exclusive read-modify-write turns: arbiter reads the line, pulses that client's vram_turn, then commits the client's modified line.
- Sits between the text writers and the VRAM block RAM; display scan-out can stall new grants via disp_hold.

---
 rtl/vram_line_arbiter_pkg.sv | 16 +
 rtl/vram_line_arbiter_rr_pick.sv | 28 ++
 rtl/vram_line_arbiter.sv | 127 ++++++++++++
 tb/tb_vram_line_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_line_arbiter_pkg.sv
// Shared definitions for the VRAM line arbiter, the text writers and the display scanner.
package vram_line_arbiter_pkg;

    localparam int LINE_W_DEF    = 640;
    localparam int ADDR_W_DEF    = 9;
    localparam int NUM_LINES_DEF = 480;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_TURN   = 3'd3,
        ST_COMMIT = 3'd4
    } arb_state_t;

endpackage

// File: rtl/vram_line_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester at or after rr_ptr, wrapping.
module vram_line_arbiter_rr_pick #(
    parameter int NUM_CLIENTS = 3,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_CLIENTS);
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_line_arbiter.sv
// Read-modify-write arbiter sharing one VRAM line port among text writers.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting; grants the next round-robin requester unless disp_hold
// ST_ADDR   | latched line address on vram_addr, read launched
// ST_WAIT   | counting down read latency, captures vram_rdata at zero
// ST_TURN   | one-cycle vram_turn pulse to the granted client
// ST_COMMIT | writes the client's modified line back if it asked to
module vram_line_arbiter
    import vram_line_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_LINES   = NUM_LINES_DEF,
    parameter int RD_LAT      = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          disp_hold,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
    input  logic [NUM_CLIENTS-1:0]        client_we,
    input  logic [NUM_CLIENTS*LINE_W-1:0] client_line,
    output logic [NUM_CLIENTS-1:0]        vram_turn,
    output logic [LINE_W-1:0]             line_to_clients,
    output logic [ADDR_W-1:0]             vram_addr,
    input  logic [LINE_W-1:0]             vram_rdata,
    output logic [LINE_W-1:0]             vram_wdata,
    output logic                          vram_we,
    output logic                          busy,
    output logic                          oob
);

    localparam int                IDX_W     = $clog2(NUM_CLIENTS);
    localparam logic [ADDR_W:0]   LINES_LIM = (ADDR_W + 1)'(NUM_LINES);
    localparam logic [1:0]        WAIT_LOAD = 2'(RD_LAT - 1);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  gnt_q, rr_ptr, pick_idx;
    logic              pick_valid, start, oob_q, sel_oob;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_arr [NUM_CLIENTS];
    logic [LINE_W-1:0] line_arr [NUM_CLIENTS];
    logic [ADDR_W-1:0] addr_sel;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign addr_arr[i] = client_addr[i*ADDR_W +: ADDR_W];
        assign line_arr[i] = client_line[i*LINE_W +: LINE_W];
    end

    vram_line_arbiter_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    assign start    = (state == ST_IDLE) && !disp_hold && pick_valid;
    assign addr_sel = addr_arr[pick_idx];
    assign sel_oob  = {1'b0, addr_sel} >= LINES_LIM;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Grant latch, read-latency counter, read capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q           <= '0;
            oob_q           <= 1'b0;
            vram_addr       <= '0;
            wait_cnt        <= '0;
            line_to_clients <= '0;
            rr_ptr          <= '0;
        end else begin
            if (start) begin
                gnt_q     <= pick_idx;
                oob_q     <= sel_oob;
                // Out-of-range lines still perform a harmless read of line 0.
                vram_addr <= sel_oob ? '0 : addr_sel;
            end
            if (state == ST_ADDR) wait_cnt <= WAIT_LOAD;
            if (state == ST_WAIT) begin
                if (wait_cnt == 2'd0) line_to_clients <= vram_rdata;
                else                  wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == ST_COMMIT)
                rr_ptr <= (gnt_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_q + 1'b1;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        vram_turn  = '0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        busy       = (state != ST_IDLE);
        oob        = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ADDR;
            ST_ADDR: begin
                oob       = oob_q;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:   if (wait_cnt == 2'd0) state_nxt = ST_TURN;
            ST_TURN: begin
                vram_turn[gnt_q] = 1'b1;
                state_nxt        = ST_COMMIT;
            end
            ST_COMMIT: begin
                vram_we    = client_we[gnt_q] && !oob_q;
                vram_wdata = vram_we ? line_arr[gnt_q] : '0;
                state_nxt  = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_line_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) share one random stimulus
// stream; a transaction-level model per lane predicts turns, writes, busy and oob.
module tb_vram_line_arbiter;

    localparam int N  = 3;
    localparam int LW = 640;
    localparam int AW = 9;
    localparam int NL = 480;

    typedef struct {
        int            g;
        logic [LW-1:0] line;
        int            cyc;
    } turn_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
        int            cyc;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            disp_hold;
    logic [N-1:0]    req;
    logic [N*AW-1:0] client_addr;
    logic [N-1:0]    client_we;
    logic [N*LW-1:0] client_line;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input bit ok, input string got, input string exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", nm, got, exp);
    endfunction

    // Deterministic VRAM contents: each line's value is a function of its address.
    function automatic logic [LW-1:0] line_of(input int a);
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++)
            r[i*32 +: 32] = ((32'(a) + 32'd1) * 32'h9E3779B1) ^ (32'(i) << 20);
        return r;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int LAT = (k == 0) ? 1 : 3;

        logic [N-1:0]  turn;
        logic [LW-1:0] ltc, rdata, wdata;
        logic [AW-1:0] vaddr;
        logic          we, busy, oob, all_zero;
        logic [AW-1:0] pipe [LAT];

        turn_t tq[$];
        wr_t   wq[$];
        bit    busy_exp = 1'b0;
        bit    oob_exp  = 1'b0;

        vram_line_arbiter #(
            .NUM_CLIENTS (N),
            .LINE_W      (LW),
            .ADDR_W      (AW),
            .NUM_LINES   (NL),
            .RD_LAT      (LAT)
        ) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .disp_hold       (disp_hold),
            .req             (req),
            .client_addr     (client_addr),
            .client_we       (client_we),
            .client_line     (client_line),
            .vram_turn       (turn),
            .line_to_clients (ltc),
            .vram_addr       (vaddr),
            .vram_rdata      (rdata),
            .vram_wdata      (wdata),
            .vram_we         (we),
            .busy            (busy),
            .oob             (oob)
        );

        // VRAM: read data appears LAT cycles after the address.
        always @(posedge clk) begin
            pipe[0] <= vaddr;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata    = line_of(int'(pipe[LAT-1]));
        assign all_zero = (turn == '0) && !we && !busy && !oob && (vaddr == '0) &&
                          (wdata == '0) && (ltc == '0);

        // Reference model: a transaction occupies grant cycle + ADDR + LAT waits + TURN + COMMIT.
        initial begin
            int            phase, rr, g;
            bit            ob, found;
            logic [AW-1:0] a;
            phase = -1; rr = 0; g = 0; ob = 1'b0; a = '0;
            forever begin
                @(posedge clk);
                #2;
                if (!rst_n) begin
                    phase = -1; rr = 0;
                    tq.delete(); wq.delete();
                    busy_exp = 1'b0; oob_exp = 1'b0;
                end else begin
                    if (phase >= 0) begin
                        phase++;
                        if (phase > 3 + LAT) phase = -1;
                    end
                    if (phase < 0 && !disp_hold && req != '0) begin
                        found = 1'b0;
                        for (int j = 0; j < N; j++)
                            if (!found && req[(rr + j) % N]) begin
                                g = (rr + j) % N;
                                found = 1'b1;
                            end
                        a  = client_addr[g*AW +: AW];
                        ob = (int'(a) >= NL);
                        phase = 0;
                        tq.push_back('{g, line_of(ob ? 0 : int'(a)), cyc + 2 + LAT});
                    end
                    if (phase == 3 + LAT) begin
                        if (client_we[g] && !ob) wq.push_back('{a, client_line[g*LW +: LW], cyc});
                        rr = (g + 1) % N;
                    end
                    busy_exp = (phase >= 1);
                    oob_exp  = (phase == 1) && ob;
                end
            end
        end

        // Monitor: compares every presented turn/write against the scoreboard queues.
        initial begin
            turn_t et;
            wr_t   ew;
            forever begin
                @(negedge clk);
                chk($sformatf("L%0d busy", k), busy == busy_exp,
                    $sformatf("%b", busy), $sformatf("%b", busy_exp));
                chk($sformatf("L%0d oob", k), oob == oob_exp,
                    $sformatf("%b", oob), $sformatf("%b", oob_exp));
                if (turn != '0) begin
                    if (tq.size() == 0) begin
                        chk($sformatf("L%0d turn_unexpected", k), 1'b0,
                            $sformatf("%b", turn), "no turn");
                    end else begin
                        et = tq.pop_front();
                        chk($sformatf("L%0d turn_onehot", k), turn == N'(1 << et.g),
                            $sformatf("%b", turn), $sformatf("%b", N'(1 << et.g)));
                        chk($sformatf("L%0d turn_line", k), ltc == et.line,
                            $sformatf("%h", ltc), $sformatf("%h", et.line));
                        chk($sformatf("L%0d turn_cycle", k), cyc == et.cyc,
                            $sformatf("%0d", cyc), $sformatf("%0d", et.cyc));
                    end
                end
                if (we) begin
                    if (wq.size() == 0) begin
                        chk($sformatf("L%0d write_unexpected", k), 1'b0,
                            $sformatf("addr %0d", vaddr), "no write");
                    end else begin
                        ew = wq.pop_front();
                        chk($sformatf("L%0d wr_addr", k), vaddr == ew.a,
                            $sformatf("%0d", vaddr), $sformatf("%0d", ew.a));
                        chk($sformatf("L%0d wr_data", k), wdata == ew.d,
                            $sformatf("%h", wdata), $sformatf("%h", ew.d));
                        chk($sformatf("L%0d wr_cycle", k), cyc == ew.cyc,
                            $sformatf("%0d", cyc), $sformatf("%0d", ew.cyc));
                    end
                end
            end
        end
    end

    task automatic rand_line(output logic [LW-1:0] l);
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    endtask

    task automatic set_client(input int i, input int a, input bit w);
        logic [LW-1:0] l;
        rand_line(l);
        client_addr[i*AW +: AW] = AW'(a);
        client_we[i]            = w;
        client_line[i*LW +: LW] = l;
    endtask

    task automatic cycles(input int n, input bit dh, input logic [N-1:0] r);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            disp_hold = dh;
            req       = r;
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " L0"}, g_lane[0].all_zero, $sformatf("%b", g_lane[0].all_zero), "1");
        chk({nm, " L1"}, g_lane[1].all_zero, $sformatf("%b", g_lane[1].all_zero), "1");
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; disp_hold = 1'b0; req = '0;
        client_addr = '0; client_we = '0; client_line = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;

        // Single client read-modify-write at line 250; req drops right after the grant.
        set_client(0, 250, 1'b1);
        cycles(1, 1'b0, 3'b001);
        cycles(12, 1'b0, 3'b000);

        // All three clients requesting continuously.
        set_client(0, 10, 1'b1); set_client(1, 20, 1'b1); set_client(2, 30, 1'b1);
        cycles(48, 1'b0, 3'b111);
        cycles(10, 1'b0, 3'b000);

        // disp_hold blocks grants, then release; then hold raised mid-transaction.
        set_client(1, 77, 1'b1);
        cycles(8, 1'b1, 3'b010);
        cycles(10, 1'b0, 3'b010);
        cycles(1, 1'b0, 3'b000);
        cycles(1, 1'b0, 3'b010);
        cycles(2, 1'b0, 3'b000);
        cycles(10, 1'b1, 3'b000);
        cycles(2, 1'b0, 3'b000);

        // Out-of-range address: turn given, write suppressed.
        set_client(2, 480, 1'b1);
        cycles(1, 1'b0, 3'b100);
        cycles(10, 1'b0, 3'b000);

        // client_we low: no write.
        set_client(0, 5, 1'b0);
        cycles(1, 1'b0, 3'b001);
        cycles(10, 1'b0, 3'b000);

        // Randomized traffic, including out-of-range addresses and disp_hold.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++)
                set_client(c, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
            cycles(1, ($urandom_range(0, 3) == 0), N'($urandom_range(0, 7)));
        end
        cycles(12, 1'b0, 3'b000);

        // Reset asserted during a turn aborts the transaction.
        set_client(1, 100, 1'b1);
        cycles(1, 1'b0, 3'b010);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (g_lane[0].turn != '0) found = 1'b1;
        end
        chk("rst_wait_turn", found, $sformatf("%b", found), "1");
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid_turn");
        @(posedge clk);
        @(posedge clk);
        #1;
        set_client(2, 300, 1'b1);
        rst_n = 1'b1;
        req   = 3'b100;
        cycles(12, 1'b0, 3'b100);
        cycles(20, 1'b0, 3'b000);

        chk("L0 turns_left",  g_lane[0].tq.size() == 0, $sformatf("%0d", g_lane[0].tq.size()), "0");
        chk("L0 writes_left", g_lane[0].wq.size() == 0, $sformatf("%0d", g_lane[0].wq.size()), "0");
        chk("L1 turns_left",  g_lane[1].tq.size() == 0, $sformatf("%0d", g_lane[1].tq.size()), "0");
        chk("L1 writes_left", g_lane[1].wq.size() == 0, $sformatf("%0d", g_lane[1].wq.size()), "0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
